// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } txbuf_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO with occupancy count and sticky overflow flag.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  byte_t         wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  output byte_t         rd_data,
  output logic          full,
  output logic          empty,
  output logic [ADDR_W:0] count,
  output logic          overflow
);

  localparam logic [ADDR_W:0] PtrInc = {{ADDR_W{1'b0}}, 1'b1};

  byte_t           mem [DEPTH];
  logic [ADDR_W:0] wr_ptr_q;
  logic [ADDR_W:0] rd_ptr_q;
  logic            overflow_q;
  logic            push;
  logic            pop;

  // Status is derived purely from registered pointers.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
            (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    count = wr_ptr_q - rd_ptr_q;
    // A same-cycle pop never frees room for a push: full is pre-edge state.
    push  = wr_en && !full;
    pop   = rd_en && !empty;
  end

  assign rd_data  = mem[rd_ptr_q[ADDR_W-1:0]];
  assign overflow = overflow_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Pointer and sticky overflow update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrInc;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrInc;
      end
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer: absorbs core output bursts in a FIFO and drains it into
// uart_tx one byte per tx_start / tx_busy handshake.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  byte_t           wr_data,
  input  logic            wr_en,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  output byte_t           txdata,
  output logic            tx_start,
  input  logic            tx_busy
);

  txbuf_state_t state_q;
  byte_t        txdata_q;
  logic         tx_start_q;
  byte_t        fifo_rd_data;
  logic         fifo_empty;
  logic         fifo_rd_en;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (fifo_rd_en),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (fifo_empty),
    .count    (count),
    .overflow (overflow)
  );

  // Pop exactly when IDLE launches a byte.
  assign fifo_rd_en = (state_q == IDLE) && !fifo_empty;

  // Drain FSM; WAIT_BUSY covers uart_tx's one-cycle registered busy response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      txdata_q   <= '0;
      tx_start_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            txdata_q   <= fifo_rd_data;
            tx_start_q <= 1'b1;
            state_q    <= WAIT_BUSY;
          end else begin
            tx_start_q <= 1'b0;
          end
        end
        WAIT_BUSY: begin
          tx_start_q <= 1'b0;
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          tx_start_q <= 1'b0;
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign txdata   = txdata_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer with a behavioural uart_tx stub.
module tb_uart_tx_buffer;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned ADDR_W   = $clog2(DEPTH);
  localparam int unsigned BUSY_LEN = 4;

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic [7:0]      wr_data  = 8'h00;
  logic            wr_en    = 1'b0;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic [7:0]      txdata;
  logic            tx_start;
  logic            tx_busy  = 1'b0;

  logic        force_busy = 1'b0;
  int unsigned busy_cnt   = 0;

  int         checks   = 0;
  int         errors   = 0;
  int         n_starts = 0;
  logic [7:0] sb[$];
  logic [7:0] held     = 8'h00;
  bit         has_held = 1'b0;
  logic       prev_start = 1'b0;

  always #5 clk = ~clk;

  uart_tx_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .txdata   (txdata),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  // uart_tx stub: busy rises one cycle after it samples tx_start, lasts BUSY_LEN cycles.
  always @(posedge clk) begin
    if (force_busy) begin
      tx_busy <= 1'b1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= BUSY_LEN - 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every tx_start pops the scoreboard; txdata must hold while busy.
  always @(negedge clk) begin
    if (rst) begin
      has_held = 1'b0;
    end else begin
      if (prev_start) begin
        check("tx_start_width", 32'(tx_start), 32'd0);
      end
      if (tx_start) begin
        n_starts++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_start: got txdata %0h expected no start", txdata);
        end else begin
          held = sb.pop_front();
          has_held = 1'b1;
          check("tx_order", 32'(txdata), 32'(held));
        end
      end else if (tx_busy && has_held) begin
        check("txdata_hold", 32'(txdata), 32'(held));
      end
    end
    prev_start = tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    wr_data = d;
    wr_en   = 1'b1;
    if (accept) sb.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || tx_busy || count != 0) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s: drain timeout, got %0d bytes pending expected 0", name, sb.size());
    end
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_txdata", 32'(txdata), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    rst = 1'b0;

    // Single push into empty FIFO: start the following cycle
    push(8'h41, 1'b1);
    check("t1_start_early", 32'(tx_start), 0);
    check("t1_count_after_push", 32'(count), 1);
    tick();
    check("t1_start", 32'(tx_start), 1);
    check("t1_txdata", 32'(txdata), 32'h41);
    check("t1_count_after_pop", 32'(count), 0);
    push(8'h42, 1'b1);
    check("t1_start_pulse_end", 32'(tx_start), 0);
    check("t1_count_second", 32'(count), 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_start && n < 50);
    check("t1_second_start_latency", 32'(n), BUSY_LEN + 2);
    wait_drain("t1_drain");

    // Burst of 16 consecutive pushes never fills the FIFO
    s0 = n_starts;
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b1);
      check("t2_full", 32'(full), 0);
    end
    wait_drain("t2_drain");
    check("t2_starts", 32'(n_starts - s0), 16);
    check("t2_overflow", 32'(overflow), 0);

    // Fill to DEPTH with busy stuck high, then overflow with 8'hFF
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      push(8'(8'h80 + i), 1'b1);
    end
    check("t3_full", 32'(full), 1);
    check("t3_count", 32'(count), 16);
    check("t3_overflow_before", 32'(overflow), 0);
    push(8'hFF, 1'b0);
    check("t3_full_after", 32'(full), 1);
    check("t3_count_after", 32'(count), 16);
    check("t3_overflow", 32'(overflow), 1);
    force_busy = 1'b0;
    wait_drain("t3_drain");
    check("t3_overflow_sticky", 32'(overflow), 1);
    check("t3_count_empty", 32'(count), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t3_overflow_cleared", 32'(overflow), 0);

    // Push and pop in the same cycle with count==3
    force_busy = 1'b1;
    tick();
    push(8'hA0, 1'b1);
    push(8'hA1, 1'b1);
    push(8'hA2, 1'b1);
    push(8'hA3, 1'b1);
    repeat (2) tick();
    check("t4_count_before", 32'(count), 3);
    force_busy = 1'b0;
    tick();
    tick();
    check("t4_count_idle", 32'(count), 3);
    check("t4_no_start_yet", 32'(tx_start), 0);
    push(8'hA4, 1'b1);
    check("t4_count_same", 32'(count), 3);
    check("t4_start", 32'(tx_start), 1);
    check("t4_txdata", 32'(txdata), 32'hA1);
    wait_drain("t4_drain");

    // Spaced pushes wrap the pointers
    s0 = n_starts;
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h30 + i), 1'b1);
      repeat (22) tick();
    end
    check("t5_starts", 32'(n_starts - s0), 20);
    check("t5_sb_empty", 32'(sb.size()), 0);

    // Reset while in WAIT_DONE with 5 bytes queued
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      push(8'(8'h60 + i), 1'b1);
    end
    repeat (2) tick();
    check("t6_count_queued", 32'(count), 5);
    rst = 1'b1;
    sb.delete();
    tick();
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_start", 32'(tx_start), 0);
    check("t6_rst_txdata", 32'(txdata), 0);
    check("t6_rst_full", 32'(full), 0);
    rst = 1'b0;
    s0 = n_starts;
    repeat (30) tick();
    check("t6_no_starts", 32'(n_starts - s0), 0);
    // Busy still high: FSM must be IDLE and launch without waiting
    push(8'h5A, 1'b1);
    tick();
    check("t6_new_start", 32'(tx_start), 1);
    check("t6_new_txdata", 32'(txdata), 32'h5A);
    force_busy = 1'b0;
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
